tpu_sched_ctrl: RTL and testbench

Sequencer for the batched systolic-array TPU. On tpu_start it streams the skewed weight/input SRAM queues through one shared read address and pulses accumulator clears at each batch boundary. It then drives per-batch write strobes and diagonal addresses into the output SRAM banks and flags tpu_finish. It sits inside tpu_top_wrap between the SRAM generators and the array, replacing ad-hoc counters.

---
 rtl/tpu_sched_ctrl.sv | 146 ++++++++++++++
 tb/tb_tpu_sched_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_sched_ctrl.sv
// Slot sequencer for the batched systolic-array TPU.
// Streams shared SRAM reads, accumulator clears and per-bank diagonal writes.
module tpu_sched_ctrl #(
    parameter  int ARRAY_SIZE      = 8,
    parameter  int BATCH_SIZE      = 3,
    parameter  int QUEUE_SIZE      = 4,
    parameter  int SRAM_ADDR_WIDTH = 10,
    parameter  int OUT_LAT         = 13,
    localparam int MATRIX_BITS     = $clog2(2*ARRAY_SIZE-1)
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic                              tpu_start,
    input  logic                              stall,
    output logic                              sram_rd_en,
    output logic [SRAM_ADDR_WIDTH-1:0]        sram_raddr,
    output logic                              acc_clr,
    output logic [BATCH_SIZE-1:0]             out_wr_en,
    output logic [BATCH_SIZE*MATRIX_BITS-1:0] out_waddr,
    output logic                              busy,
    output logic                              tpu_finish
);

    localparam int FEED_LEN = BATCH_SIZE*ARRAY_SIZE + QUEUE_SIZE - 1;
    localparam int NDIAG    = 2*ARRAY_SIZE - 1;
    localparam int LAST     = (BATCH_SIZE-1)*ARRAY_SIZE + OUT_LAT + NDIAG - 1;
    localparam int CNT_W    = $clog2(LAST + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  slot_q, slot_d;
    logic                              rd_en_q, rd_en_d;
    logic [SRAM_ADDR_WIDTH-1:0]        raddr_q, raddr_d;
    logic                              clr_q, clr_d;
    logic [BATCH_SIZE-1:0]             wr_en_q, wr_en_d;
    logic [BATCH_SIZE*MATRIX_BITS-1:0] waddr_q, waddr_d;
    logic                              busy_q, busy_d;
    logic                              finish_q, finish_d;

    logic             emit;
    logic [CNT_W-1:0] k_cur;
    int               kk;
    int               lo;

    // Next state, slot advance and the registered actions of the emitted slot
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        finish_d = finish_q;
        rd_en_d  = 1'b0;
        raddr_d  = '0;
        clr_d    = 1'b0;
        wr_en_d  = '0;
        waddr_d  = '0;
        emit     = 1'b0;
        k_cur    = slot_q;
        kk       = 0;
        lo       = 0;

        unique case (state_q)
            IDLE, DONE: begin
                if (tpu_start) begin
                    state_d  = ACTIVE;
                    finish_d = 1'b0;
                    k_cur    = '0;
                    slot_d   = '0;
                    emit     = !stall;
                end
            end
            ACTIVE: begin
                if (!stall) begin
                    if (slot_q == CNT_W'(LAST + 1)) begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit) begin
            slot_d = k_cur + CNT_W'(1);
            kk     = int'(k_cur);
            if (kk < FEED_LEN) begin
                rd_en_d = 1'b1;
                raddr_d = SRAM_ADDR_WIDTH'(kk);
            end
            for (int b = 0; b < BATCH_SIZE; b++) begin
                if (kk == b*ARRAY_SIZE) begin
                    clr_d = 1'b1;
                end
                lo = b*ARRAY_SIZE + OUT_LAT;
                if (kk >= lo && kk < lo + NDIAG) begin
                    wr_en_d[b] = 1'b1;
                    waddr_d[b*MATRIX_BITS +: MATRIX_BITS] =
                        MATRIX_BITS'(kk - lo);
                end
            end
        end

        busy_d = (state_d == ACTIVE);
    end

    // State, slot counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            rd_en_q  <= 1'b0;
            raddr_q  <= '0;
            clr_q    <= 1'b0;
            wr_en_q  <= '0;
            waddr_q  <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            rd_en_q  <= rd_en_d;
            raddr_q  <= raddr_d;
            clr_q    <= clr_d;
            wr_en_q  <= wr_en_d;
            waddr_q  <= waddr_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign sram_rd_en = rd_en_q;
    assign sram_raddr = raddr_q;
    assign acc_clr    = clr_q;
    assign out_wr_en  = wr_en_q;
    assign out_waddr  = waddr_q;
    assign busy       = busy_q;
    assign tpu_finish = finish_q;

endmodule

// File: tb/tb_tpu_sched_ctrl.sv
// Directed testbench for tpu_sched_ctrl with default parameters.
// Timelines are expressed relative to the cycle S in which tpu_start is sampled.
module tb_tpu_sched_ctrl;

    logic        clk;
    logic        srst;
    logic        tpu_start;
    logic        stall;
    logic        sram_rd_en;
    logic [9:0]  sram_raddr;
    logic        acc_clr;
    logic [2:0]  out_wr_en;
    logic [11:0] out_waddr;
    logic        busy;
    logic        tpu_finish;

    int n_cmp;
    int n_err;

    tpu_sched_ctrl dut (
        .clk        (clk),
        .srst       (srst),
        .tpu_start  (tpu_start),
        .stall      (stall),
        .sram_rd_en (sram_rd_en),
        .sram_raddr (sram_raddr),
        .acc_clr    (acc_clr),
        .out_wr_en  (out_wr_en),
        .out_waddr  (out_waddr),
        .busy       (busy),
        .tpu_finish (tpu_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector for slot k (k<0 or k>43 means no strobes)
    function automatic logic [28:0] exp_vec(input int k, input bit bz, input bit fn);
        logic        rd;
        logic [9:0]  ra;
        logic        clr;
        logic [2:0]  we;
        logic [11:0] wa;
        int          lo;
        rd  = 1'b0;
        ra  = '0;
        clr = 1'b0;
        we  = '0;
        wa  = '0;
        if (k >= 0 && k <= 43) begin
            if (k < 27) begin
                rd = 1'b1;
                ra = 10'(k);
            end
            clr = (k == 0) || (k == 8) || (k == 16);
            for (int b = 0; b < 3; b++) begin
                lo = 13 + 8*b;
                if (k >= lo && k <= lo + 14) begin
                    we[b] = 1'b1;
                    wa[b*4 +: 4] = 4'(k - lo);
                end
            end
        end
        return {rd, ra, clr, we, wa, bz, fn};
    endfunction

    function automatic logic [28:0] obs_vec();
        return {sram_rd_en, sram_raddr, acc_clr, out_wr_en, out_waddr,
                busy, tpu_finish};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [28:0] obs;
        srst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tpu_start = 1'($urandom_range(0, 1));
            stall     = 1'($urandom_range(0, 1));
            tick();
            obs = obs_vec();
            n_cmp++;
            if (obs !== 29'h0) begin
                n_err++;
                $display("FAIL reset_cyc%0d got=%h exp=%h", i, obs, 29'h0);
            end
        end
        srst      = 1'b0;
        tpu_start = 1'b0;
        stall     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            obs = obs_vec();
            n_cmp++;
            if (obs !== 29'h0) begin
                n_err++;
                $display("FAIL post_reset_cyc%0d got=%h exp=%h", i, obs, 29'h0);
            end
        end
    endtask

    // Full run from the current cycle S: stall=1 in relative cycles
    // sa..sb (sampled at the end of that cycle), tpu_start pulse at pa.
    task automatic run(input int sa, input int sb, input int pa, input string nm);
        int          ns;
        int          k;
        int          total;
        int          wc [3];
        logic [28:0] obs;
        logic [28:0] ex;
        ns    = (sa <= sb) ? (sb - sa + 1) : 0;
        total = 47 + ns;
        for (int b = 0; b < 3; b++) wc[b] = 0;
        tpu_start = 1'b1;
        stall     = (sa <= 0) && (0 <= sb);
        for (int c = 1; c <= total; c++) begin
            tick();
            if (ns == 0 || c <= sa) k = c - 1;
            else if (c <= sb + 1)   k = -1;
            else                    k = c - 1 - ns;
            ex  = exp_vec(k, (c <= 44 + ns), (c >= 45 + ns));
            obs = obs_vec();
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL %s_cyc%0d got=%h exp=%h", nm, c, obs, ex);
            end
            for (int b = 0; b < 3; b++) if (out_wr_en[b] === 1'b1) wc[b]++;
            tpu_start = (c == pa);
            stall     = (c >= sa) && (c <= sb);
        end
        tpu_start = 1'b0;
        stall     = 1'b0;
        for (int b = 0; b < 3; b++) begin
            n_cmp++;
            if (wc[b] != 15) begin
                n_err++;
                $display("FAIL %s_writes_bank%0d got=%0d exp=15", nm, b, wc[b]);
            end
        end
    endtask

    task automatic test_nominal();
        run(-10, -11, -1, "nominal");
    endtask

    task automatic test_stall_mid();
        run(11, 13, -1, "stall_mid");
    endtask

    task automatic test_start_ignored();
        run(-10, -11, 20, "start_in_active");
    endtask

    task automatic test_restart_from_done();
        run(-10, -11, -1, "restart_done");
    endtask

    task automatic test_srst_mid();
        logic [28:0] obs;
        logic [28:0] ex;
        tpu_start = 1'b1;
        stall     = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            tick();
            tpu_start = 1'b0;
            ex  = exp_vec(c - 1, 1'b1, 1'b0);
            obs = obs_vec();
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL srst_pre_cyc%0d got=%h exp=%h", c, obs, ex);
            end
        end
        srst = 1'b1;
        tick();
        srst = 1'b0;
        obs  = obs_vec();
        n_cmp++;
        if (obs !== 29'h0) begin
            n_err++;
            $display("FAIL srst_clear got=%h exp=%h", obs, 29'h0);
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            obs = obs_vec();
            n_cmp++;
            if (obs !== 29'h0) begin
                n_err++;
                $display("FAIL srst_quiet_cyc%0d got=%h exp=%h", c, obs, 29'h0);
            end
        end
        run(-10, -11, -1, "after_srst");
    endtask

    task automatic test_start_stalled();
        run(0, 4, -1, "start_stalled");
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        srst      = 1'b0;
        tpu_start = 1'b0;
        stall     = 1'b0;
        test_reset();
        test_nominal();
        test_stall_mid();
        test_start_ignored();
        test_restart_from_done();
        test_srst_mid();
        test_start_stalled();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
